// File: rtl/axis_pkg.sv
// axis_pkg: shared state encoding and byte-keep helpers for the header inserter
package axis_pkg;
  localparam int MAX_BYTES = 64;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_TAIL} state_e;
  function automatic logic [MAX_BYTES-1:0] keep_from_cnt(input int n, input int cnt);
    logic [MAX_BYTES-1:0] k;
    for (int i = 0; i < MAX_BYTES; i++) k[i] = (i < n) && (i >= n - cnt);
    return k;
  endfunction
  function automatic int popcount(input logic [MAX_BYTES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/axis_byte_merge.sv
// axis_byte_merge: joins h carried bytes with the top bytes of a payload beat
module axis_byte_merge import axis_pkg::*; #(
  parameter int DATA_WD = 32,
  parameter int N = DATA_WD/8,
  parameter int CW = $clog2(N)+1
)(
  input  logic [DATA_WD-1:0] carry,
  input  logic [DATA_WD-1:0] data,
  input  logic [CW-1:0]      h,
  input  logic [CW-1:0]      k,
  output logic [DATA_WD-1:0] data_o,
  output logic [N-1:0]       keep_o,
  output logic               ovf
);
  int tot;
  // carry fills the top h bytes, payload slides down; overflow means a tail beat is needed
  always_comb begin
    tot = int'(h) + int'(k);
    ovf = tot > N;
    data_o = (carry << ((N - int'(h)) * 8)) | (data >> (int'(h) * 8));
    keep_o = ovf ? '1 : N'(keep_from_cnt(N, tot));
  end
endmodule

// File: rtl/axis_header_insert_pkt.sv
// axis_header_insert_pkt: prepends a 0..N byte header to each AXI-Stream packet
module axis_header_insert_pkt import axis_pkg::*; #(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD)+1,
  parameter int PKT_CNT_WD = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic [PKT_CNT_WD-1:0]   pkt_cnt,
  output logic                    err_sticky
);
  localparam int N = DATA_BYTE_WD;
  state_e state_q, state_d;
  logic [DATA_WD-1:0] carry_q, carry_d, data_q, data_d, m_data;
  logic [N-1:0] keep_q, keep_d, m_keep, hkeep, kexp;
  logic [BYTE_CNT_WD-1:0] h_q, h_d, k_q, k_d, h_in, k_in, k_mrg;
  logic [PKT_CNT_WD-1:0] pkt_q, pkt_d;
  logic valid_q, valid_d, last_q, last_d, rdy_ins_q, rdy_ins_d, err_q, err_d;
  logic m_ovf, out_free, fire_in, fire_hdr;

  axis_byte_merge #(.DATA_WD(DATA_WD), .N(N), .CW(BYTE_CNT_WD)) u_merge (
    .carry(carry_q), .data(data_in), .h(h_q), .k(k_mrg),
    .data_o(m_data), .keep_o(m_keep), .ovf(m_ovf)
  );

  // next-state logic: header capture, payload merge, tail flush and error tracking
  always_comb begin
    out_free = !valid_q | ready_out;
    ready_in = (state_q == S_STREAM) && out_free;
    fire_in = valid_in & ready_in;
    fire_hdr = valid_insert & rdy_ins_q;
    h_in = (byte_insert_cnt > BYTE_CNT_WD'(N)) ? BYTE_CNT_WD'(N) : byte_insert_cnt;
    hkeep = ~({N{1'b1}} << h_in);
    k_in = BYTE_CNT_WD'(popcount(MAX_BYTES'(keep_in)));
    k_mrg = last_in ? k_in : BYTE_CNT_WD'(N);
    kexp = last_in ? N'(keep_from_cnt(N, int'(k_in))) : '1;
    state_d = state_q;
    carry_d = carry_q;
    h_d = h_q;
    k_d = k_q;
    err_d = err_q;
    valid_d = valid_q & !ready_out;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    pkt_d = pkt_q + PKT_CNT_WD'(valid_q & ready_out & last_q);
    if (fire_hdr) begin
      carry_d = data_insert & ~({DATA_WD{1'b1}} << (int'(h_in) * 8));
      h_d = h_in;
      state_d = S_STREAM;
      err_d = err_q | (byte_insert_cnt > BYTE_CNT_WD'(N)) | (keep_insert != hkeep);
    end
    if (fire_in) begin
      valid_d = 1'b1;
      data_d = m_data;
      keep_d = m_keep;
      last_d = last_in & !m_ovf;
      carry_d = data_in & ~({DATA_WD{1'b1}} << (int'(h_q) * 8));
      k_d = k_in;
      err_d = err_d | (keep_in != kexp) | (last_in && k_in == '0);
      if (last_in) state_d = m_ovf ? S_TAIL : S_IDLE;
    end
    if (state_q == S_TAIL && out_free) begin
      valid_d = 1'b1;
      data_d = carry_q << ((N - int'(h_q)) * 8);
      keep_d = N'(keep_from_cnt(N, int'(h_q) + int'(k_q) - N));
      last_d = 1'b1;
      state_d = S_IDLE;
    end
    rdy_ins_d = state_d == S_IDLE;
  end

  // state, carry and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      carry_q <= '0;
      h_q <= '0;
      k_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      pkt_q <= '0;
      rdy_ins_q <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      h_q <= h_d;
      k_q <= k_d;
      err_q <= err_d;
      valid_q <= valid_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      pkt_q <= pkt_d;
      rdy_ins_q <= rdy_ins_d;
    end
  end

  assign ready_insert = rdy_ins_q;
  assign valid_out = valid_q;
  assign data_out = data_q;
  assign keep_out = keep_q;
  assign last_out = last_q;
  assign pkt_cnt = pkt_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_axis_header_insert_pkt.sv
// tb_axis_header_insert_pkt: directed and randomized checks of the header inserter
module tb_axis_header_insert_pkt;
  logic clk, rst;
  logic valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0] keep_in;
  logic valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0] keep_insert;
  logic [2:0] byte_insert_cnt;
  logic valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0] keep_out;
  logic [15:0] pkt_cnt;
  logic err_sticky;
  int checks = 0, errors = 0;
  bit rnd = 0;

  typedef struct {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  beat_t exp_q[$];

  axis_header_insert_pkt dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out), .pkt_cnt(pkt_cnt), .err_sticky(err_sticky)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_q.push_back(b);
  endtask

  // downstream ready: always high, or ~70% high when randomized
  initial begin
    ready_out = 0;
    forever begin
      @(posedge clk); #1;
      ready_out = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  // output monitor: scoreboard compare and stall-hold checks
  logic stall_prev = 0;
  logic [36:0] prev;
  always @(negedge clk) begin
    if (stall_prev && !rst) begin
      check("hold_valid", valid_out, 1);
      check("hold_beat", {keep_out, last_out, data_out}, prev);
    end
    if (valid_out && ready_out) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_beat observed=%h expected=none", data_out);
      end
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("out_data", data_out & kmask(e.k), e.d & kmask(e.k));
        check("out_keep", keep_out, e.k);
        check("out_last", last_out, e.l);
      end
    end
    stall_prev = valid_out && !ready_out && !rst;
    prev = {keep_out, last_out, data_out};
  end

  task automatic send_hdr(input logic [31:0] d, input logic [3:0] k, input logic [2:0] c);
    bit ok = 0;
    valid_insert = 1; data_insert = d; keep_insert = k; byte_insert_cnt = c;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk); ok = ready_insert;
      @(posedge clk); #1;
    end
    valid_insert = 0;
    check("hdr_handshake", ok, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok = 0;
    valid_in = 1; data_in = d; keep_in = k; last_in = l;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk); ok = ready_in;
      @(posedge clk); #1;
    end
    valid_in = 0;
    check("beat_handshake", ok, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk); ok = exp_q.size() == 0;
    end
    check("drain", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic model_pkt(input logic [31:0] hdr, input int h, input logic [31:0] pd[$], input int lastk);
    logic [7:0] b[$];
    logic [31:0] d;
    logic [3:0] k;
    for (int i = h - 1; i >= 0; i--) b.push_back(hdr[8*i +: 8]);
    for (int j = 0; j < pd.size(); j++) begin
      int n = (j == pd.size() - 1) ? lastk : 4;
      for (int i = 3; i > 3 - n; i--) b.push_back(pd[j][8*i +: 8]);
    end
    while (b.size() > 0) begin
      d = 0; k = 0;
      for (int i = 3; i >= 0; i--) if (b.size() > 0) begin d[8*i +: 8] = b.pop_front(); k[i] = 1; end
      push_exp(d, k, b.size() == 0);
    end
  endtask

  logic [31:0] pd[$];
  logic [31:0] hdr;
  int h, nb, lk;
  logic [3:0] lkeep;

  initial begin
    rst = 1; valid_in = 0; data_in = 0; keep_in = 0; last_in = 0;
    valid_insert = 0; data_insert = 0; keep_insert = 0; byte_insert_cnt = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_ready_in", ready_in, 0);
    check("rst_ready_insert", ready_insert, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_err", err_sticky, 0);
    rst = 0;
    push_exp(32'hAABB1122, 4'hF, 0);
    push_exp(32'h33445566, 4'hF, 0);
    push_exp(32'h77880000, 4'hC, 1);
    send_hdr(32'h0000AABB, 4'b0011, 2);
    send_beat(32'h11223344, 4'hF, 0);
    send_beat(32'h55667788, 4'hF, 1);
    push_exp(32'hAABBCC11, 4'hF, 1);
    send_hdr(32'h00AABBCC, 4'b0111, 3);
    send_beat(32'h11FFFFFF, 4'b1000, 1);
    drain();
    check("pkt_cnt_t2", pkt_cnt, 2);
    check("err_t2", err_sticky, 0);
    push_exp(32'hDEADBEEF, 4'hF, 0);
    push_exp(32'h11220000, 4'hC, 1);
    send_hdr(32'hDEADBEEF, 4'hF, 4);
    send_beat(32'h1122EEEE, 4'b1100, 1);
    push_exp(32'hCAFEBABE, 4'hF, 0);
    push_exp(32'h01020300, 4'hE, 1);
    send_hdr(32'h12345678, 4'h0, 0);
    send_beat(32'hCAFEBABE, 4'hF, 0);
    send_beat(32'h01020304, 4'hE, 1);
    drain();
    check("pkt_cnt_t3", pkt_cnt, 4);
    rnd = 1;
    for (int p = 0; p < 20; p++) begin
      hdr = $urandom; h = $urandom_range(0, 4); nb = $urandom_range(1, 4); lk = $urandom_range(1, 4);
      lkeep = 4'hF << (4 - lk);
      pd.delete();
      for (int j = 0; j < nb; j++) pd.push_back($urandom);
      model_pkt(hdr, h, pd, lk);
      send_hdr(hdr, 4'(~(4'hF << h)), 3'(h));
      for (int j = 0; j < nb; j++) send_beat(pd[j], (j == nb - 1) ? lkeep : 4'hF, j == nb - 1);
    end
    drain();
    rnd = 0;
    @(posedge clk); #1;
    check("pkt_cnt_rand", pkt_cnt, 24);
    check("err_rand", err_sticky, 0);
    send_hdr(32'h0000CCDD, 4'b0011, 2);
    send_beat(32'h99887766, 4'hF, 0);
    rst = 1;
    @(negedge clk);
    check("mid_rst_outs", {valid_out, data_out, keep_out, last_out, ready_in, ready_insert}, 0);
    check("mid_rst_cnt", {pkt_cnt, err_sticky}, 0);
    @(posedge clk); #1;
    rst = 0;
    push_exp(32'hEEFF0102, 4'hF, 0);
    push_exp(32'h03040000, 4'hC, 1);
    send_hdr(32'h0000EEFF, 4'b0011, 2);
    send_beat(32'h01020304, 4'hF, 1);
    drain();
    check("pkt_cnt_post_rst", pkt_cnt, 1);
    check("err_post_rst", err_sticky, 0);
    push_exp(32'hDEADBEEF, 4'hF, 0);
    push_exp(32'h11223344, 4'hF, 1);
    send_hdr(32'hDEADBEEF, 4'hF, 5);
    send_beat(32'h11223344, 4'hF, 1);
    drain();
    check("err_cnt5", err_sticky, 1);
    push_exp(32'hAA112233, 4'hE, 1);
    send_hdr(32'h000000AA, 4'b0001, 1);
    send_beat(32'h11223344, 4'b1010, 1);
    drain();
    check("err_keep", err_sticky, 1);
    check("pkt_cnt_end", pkt_cnt, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
